// File: rtl/spram_pkg.sv
// Shared types and constants for the single-port SPRAM (16K x 16) access path.
package spram_pkg;

    localparam int SPRAM_ADDR_W = 14;
    localparam int SPRAM_DATA_W = 16;
    localparam int SPRAM_MASK_W = 4;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WAKE    = 2'd2
    } spram_state_e;

endpackage

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority pointer advances past the winner.
module spram_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] idx_v;
    logic             found;
    int               idx;

    // Scan starting at the pointer, wrapping once around the requesters.
    always_comb begin
        gnt     = '0;
        win_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        idx_v   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = PTR_W'(idx);
            if (en && !found && req[idx_v]) begin
                found      = 1'b1;
                gnt[idx_v] = 1'b1;
                win_idx    = idx_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one SB_SPRAM256KA1 between NUM_REQ masters with round-robin grants,
// a fixed 1-cycle read return, and idle-driven STANDBY with a timed wake-up.
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = SPRAM_ADDR_W,
    parameter int DATA_W      = SPRAM_DATA_W,
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]        addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]        wdata_i,
    input  logic [NUM_REQ*SPRAM_MASK_W-1:0]  wmask_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_W-1:0]                rdata_o,
    output logic                             sleeping_o,
    output logic [ADDR_W-1:0]                spram_addr_o,
    output logic [DATA_W-1:0]                spram_din_o,
    output logic [SPRAM_MASK_W-1:0]          spram_mask_o,
    output logic                             spram_wren_o,
    output logic                             spram_cs_o,
    output logic                             spram_standby_o,
    output logic                             spram_sleep_o,
    output logic                             spram_poweroff_o,
    input  logic [DATA_W-1:0]                spram_dout_i
);

    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    spram_state_e       state;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [WAKE_W-1:0]  wake_cnt;
    logic               any_req;
    logic               active;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rd_vld_p1;

    assign any_req = |req_i;
    assign active  = (state == ST_ACTIVE);

    spram_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (active),
        .req   (req_i),
        .gnt   (gnt)
    );

    assign gnt_o = gnt;

    // One-hot grant lets the request mux be a plain AND-OR.
    always_comb begin
        spram_addr_o = '0;
        spram_din_o  = '0;
        spram_mask_o = '0;
        spram_wren_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                spram_addr_o |= addr_i[i*ADDR_W +: ADDR_W];
                spram_din_o  |= wdata_i[i*DATA_W +: DATA_W];
                spram_mask_o |= wmask_i[i*SPRAM_MASK_W +: SPRAM_MASK_W];
                spram_wren_o |= we_i[i];
            end
        end
    end

    assign spram_cs_o       = |gnt;
    assign spram_sleep_o    = 1'b0;
    assign spram_poweroff_o = 1'b1;
    assign rdata_o          = spram_dout_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_ACTIVE;
            idle_cnt        <= '0;
            wake_cnt        <= '0;
            spram_standby_o <= 1'b0;
            sleeping_o      <= 1'b0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (any_req) begin
                        idle_cnt <= '0;
                    end else if (IDLE_CYCLES != 0 && idle_cnt == IDLE_LAST) begin
                        state           <= ST_STANDBY;
                        idle_cnt        <= '0;
                        spram_standby_o <= 1'b1;
                        sleeping_o      <= 1'b1;
                    end else if (IDLE_CYCLES != 0) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_STANDBY: begin
                    if (any_req) begin
                        state           <= ST_WAKE;
                        wake_cnt        <= '0;
                        spram_standby_o <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state      <= ST_ACTIVE;
                        idle_cnt   <= '0;
                        sleeping_o <= 1'b0;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: begin
                    state           <= ST_ACTIVE;
                    spram_standby_o <= 1'b0;
                    sleeping_o      <= 1'b0;
                end
            endcase
        end
    end

    // p0 -> p1: SPRAM returns DATAOUT one cycle after a read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1 <= '0;
        end else begin
            rd_vld_p1 <= gnt & ~we_i;
        end
    end

    assign rvalid_o = rd_vld_p1;

endmodule
